// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// One transaction in flight at a time; address, command and write data are captured at grant.
module pmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  busy
);

   // Handshake: a requester holds read/write (and address/data) high until it sees its
   // resp for exactly one cycle; pmem holds the command until pmem_resp, which it pulses once.
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

   state_t state, state_next;
   logic   last_grant;
   logic   i_req, d_req;
   logic   grant_i, grant_d;
   logic   finish;

   assign i_req  = i_pmem_read;
   assign d_req  = d_pmem_read | d_pmem_write;
   assign finish = ((state == GNT_I) || (state == GNT_D)) && pmem_resp;

   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            // On a tie, last_grant=1 (D last) hands the slot to I, and vice versa.
            if (i_req && (!d_req || last_grant)) begin
               grant_i    = 1'b1;
               state_next = GNT_I;
            end else if (d_req) begin
               grant_d    = 1'b1;
               state_next = GNT_D;
            end
         end
         GNT_I:   if (pmem_resp) state_next = DONE;
         GNT_D:   if (pmem_resp) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else begin
         state <= state_next;
         if (grant_i) begin
            last_grant   <= 1'b0;
            pmem_address <= i_pmem_address;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
         end else if (grant_d) begin
            // Write wins when both D commands are high.
            last_grant   <= 1'b1;
            pmem_address <= d_pmem_address;
            pmem_read    <= ~d_pmem_write;
            pmem_write   <= d_pmem_write;
            if (d_pmem_write) pmem_wdata <= d_pmem_wdata;
         end else if (finish) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
         end
      end
   end

   assign i_pmem_resp  = (state == GNT_I) && pmem_resp;
   assign d_pmem_resp  = (state == GNT_D) && pmem_resp;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   assign busy         = (state == GNT_I) || (state == GNT_D);

   a_cmd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      !(pmem_read && pmem_write));
   a_cmd_busy: assert property (@(posedge clk) disable iff (!rst_n)
      busy == (pmem_read || pmem_write));
   a_resp_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_pmem_resp && d_pmem_resp));

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the I-cache (line reads only) and the D-cache (line reads and write-backs).
- Sits between the two L1 caches and pmem. Each cache sees a private pmem-style port.
- Round-robin arbitration, one outstanding transaction at a time. Request address, command and write data are latched at grant.

Parameters:
ADDR_WIDTH, 32, byte address width of cache and pmem ports
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  in  ADDR_WIDTH  I-cache line address
i_pmem_rdata  out  LINE_WIDTH  read data to I-cache
i_pmem_resp  out  1  I-cache transaction complete
d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
d_pmem_write  in  1  D-cache write-back request, held until d_pmem_resp
d_pmem_address  in  ADDR_WIDTH  D-cache line address
d_pmem_wdata  in  LINE_WIDTH  D-cache write-back data
d_pmem_rdata  out  LINE_WIDTH  read data to D-cache
d_pmem_resp  out  1  D-cache transaction complete
pmem_read  out  1  read command to physical memory
pmem_write  out  1  write command to physical memory
pmem_address  out  ADDR_WIDTH  address to physical memory
pmem_wdata  out  LINE_WIDTH  write data to physical memory
pmem_rdata  in  LINE_WIDTH  read data from physical memory
pmem_resp  in  1  physical memory finished operation
busy  out  1  transaction in flight (state GNT_I or GNT_D)

Behaviour:
- States: IDLE, GNT_I, GNT_D, DONE. Registered state and last_grant bit (0=I, 1=D).
- Reset (async, rst_n low): state IDLE, last_grant=1 so I wins the first tie.
  - pmem_read, pmem_write, pmem_address, pmem_wdata all 0; busy 0; i_pmem_resp and d_pmem_resp 0.
- IDLE: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - Only i_req: go GNT_I.
  - Only d_req: go GNT_D.
  - Both: grant the requester that is not last_grant.
  - Neither: stay IDLE.
- On grant edge, register the following and set last_grant to the granted side:
  - pmem_address from the granted address.
  - pmem_read/pmem_write from the granted command. I grant: read=1, write=0.
  - pmem_wdata from d_pmem_wdata on a D write; otherwise hold the previous value.
- D command encoding: d_pmem_write=1 gives a write, regardless of d_pmem_read. Both high is illegal; treat as write.
- pmem_read/pmem_write assert in the first GNT_x cycle and stay high through the pmem_resp cycle inclusive.
  - Address, command and data stay stable even if the requester changes its inputs mid-transaction.
- GNT_x with pmem_resp=1:
  - Assert the granted side's resp combinationally in the same cycle; the other side's resp stays 0.
  - Go DONE and clear pmem_read/pmem_write on that edge.
- DONE: one turnaround cycle. Requests are not sampled, which absorbs requesters that drop their request the cycle after resp. Always go IDLE.
- pmem_resp in IDLE or DONE is ignored: no resp is forwarded and there is no state change.
- i_pmem_rdata and d_pmem_rdata are both driven directly from pmem_rdata (broadcast). Validity is indicated only by the respective resp.
- Latency:
  - Request seen in IDLE at cycle 0: pmem command visible at cycle 1.
  - pmem_resp at cycle N: requester resp at cycle N, DONE at N+1, IDLE at N+2.
  - Next pmem command no earlier than N+3.
- Starvation bound: with both sides continuously requesting, grants strictly alternate.
- Reset mid-transaction: pmem_read/pmem_write drop asynchronously and no resp is forwarded. Requesters must also be reset.
- busy = 1 exactly in GNT_I and GNT_D.

Test Plan:
- I read alone: i_pmem_read=1, addr 0x0000_1040; pmem_resp after 5 cycles with rdata=0xA5 repeated.
  - Required: pmem_read=1 from cycle 1, pmem_address=0x0000_1040.
  - Required: i_pmem_resp=1 in the resp cycle, i_pmem_rdata=0xA5...; d_pmem_resp stays 0.
- D write-back alone: d_pmem_write=1, addr 0x0000_2000, wdata=0xDEAD_BEEF replicated; change wdata to 0 after cycle 1.
  - Required: pmem_write=1, pmem_wdata stays 0xDEAD_BEEF... until resp.
  - Required: d_pmem_resp pulses one cycle; pmem_write low the next cycle.
- Simultaneous requests out of reset (I read 0x100, D read 0x200, both held):
  - Required: I granted first (pmem_address=0x100).
  - Required: after I's resp and one DONE cycle, D granted (0x200). Next tie goes to I.
- Back-to-back alternation: both sides re-request immediately after each resp for 6 transactions.
  - Required: grant order I,D,I,D,I,D, each new command exactly 3 cycles after the previous pmem_resp.
- Spurious pmem_resp=1 in IDLE:
  - Required: no i/d resp asserted, state stays IDLE, busy=0.
- rst_n asserted low mid-GNT_D before pmem_resp:
  - Required: pmem_write/pmem_read go 0 immediately, busy=0.
  - Required: after release, a fresh I request is granted normally.
